// File: rtl/present_ctr_ctrl_pkg.sv
// present_pkg: shared widths, FSM states and counter increment (PRESENT_CTR_NONCE_EN keeps counter[63:32] as a fixed nonce)
package present_pkg;
  localparam int KEY_W = 80;
  localparam int BLK_W = 64;
  typedef enum logic [1:0] {NOKEY, READY, WAIT, OUT} state_t;
  function automatic logic [BLK_W-1:0] ctr_inc(input logic [BLK_W-1:0] c);
`ifdef PRESENT_CTR_NONCE_EN
    return {c[63:32], c[31:0] + 32'd1};
`else
    return c + 64'd1;
`endif
  endfunction
endpackage

// File: rtl/present_ctr_ctrl_inc.sv
// present_ctr_inc: counter register with load and post-use increment; base is the value the current block uses
module present_ctr_inc
  import present_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             inc,
  input  logic [BLK_W-1:0] d,
  output logic [BLK_W-1:0] base
);
  logic [BLK_W-1:0] cnt;
  assign base = load ? d : cnt;
  // load wins over the stored value, and a consumed block advances past whichever value it used
  always_ff @(posedge clk)
    cnt <= rst ? '0 : inc ? ctr_inc(base) : base;
endmodule

// File: rtl/present_ctr_ctrl.sv
// present_ctr_ctrl: counter-mode front end for PRESENT-80 (optional PRESENT_CTR_NONCE_EN fixes counter[63:32])
module present_ctr_ctrl
  import present_pkg::*;
#(
  parameter int CORE_LAT = 2,
  parameter int CNT_W    = BLK_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_load,
  input  logic [KEY_W-1:0] key_in,
  input  logic             iv_load,
  input  logic [CNT_W-1:0] iv_in,
  input  logic             pt_valid,
  output logic             pt_ready,
  input  logic [BLK_W-1:0] pt_data,
  output logic             ct_valid,
  input  logic             ct_ready,
  output logic [BLK_W-1:0] ct_data,
  output logic [KEY_W-1:0] core_K,
  output logic [BLK_W-1:0] core_M,
  input  logic [BLK_W-1:0] core_C,
  output logic             busy
);
  localparam int WW = $clog2(CORE_LAT + 1);
  state_t           state;
  logic [WW-1:0]    wcnt;
  logic [BLK_W-1:0] pt_reg;
  logic [CNT_W-1:0] ctr_base;
  logic             cfg;
  assign cfg      = (state == NOKEY) || (state == READY);
  assign pt_ready = state == READY;
  assign busy     = (state == WAIT) || (state == OUT);
  present_ctr_inc u_ctr (
    .clk  (clk),
    .rst  (rst),
    .load (cfg && iv_load),
    .inc  (pt_ready && pt_valid),
    .d    (iv_in),
    .base (ctr_base)
  );
  // control FSM; core_C is sampled one edge after the core has had CORE_LAT full cycles of stable inputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= NOKEY;
      wcnt     <= '0;
      pt_reg   <= '0;
      core_K   <= '0;
      core_M   <= '0;
      ct_data  <= '0;
      ct_valid <= 1'b0;
    end else begin
      if (cfg && key_load) core_K <= key_in;
      case (state)
        NOKEY: if (key_load) state <= READY;
        READY: if (pt_valid) begin
          pt_reg <= pt_data;
          core_M <= ctr_base;
          wcnt   <= WW'(CORE_LAT);
          state  <= WAIT;
        end
        WAIT: begin
          wcnt <= wcnt - WW'(1);
          if (wcnt == '0) begin
            ct_data  <= pt_reg ^ core_C;
            ct_valid <= 1'b1;
            state    <= OUT;
          end
        end
        OUT: if (ct_ready) begin
          ct_valid <= 1'b0;
          state    <= READY;
        end
        default: state <= NOKEY;
      endcase
    end
  end
endmodule

// File: tb/tb_present_ctr_ctrl.sv
// tb_present_ctr_ctrl: directed scoreboard bench with a behavioural PRESENT-80 core model
module tb_present_ctr_ctrl;
  localparam int LAT = 2;
`ifdef PRESENT_CTR_NONCE_EN
  localparam bit FULL = 1'b0;
`else
  localparam bit FULL = 1'b1;
`endif
  logic clk = 1'b0, rst = 1'b1;
  logic key_load = 0, iv_load = 0, pt_valid = 0, ct_ready = 0, pv5 = 0;
  logic [79:0] key_in = '0;
  logic [63:0] iv_in = '0, pt_data = '0;
  logic pt_ready, ct_valid, busy, pr5, cv5, busy5;
  logic [63:0] ct_data, core_M, core_C, ct5, cm5, cc5;
  logic [79:0] core_K, ck5;
  logic [63:0] cp [LAT];
  logic [63:0] cp5 [5];
  logic [63:0] sb [$];
  logic [63:0] ctr_m;
  logic [79:0] key_m;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  present_ctr_ctrl #(.CORE_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .key_load(key_load), .key_in(key_in), .iv_load(iv_load), .iv_in(iv_in),
    .pt_valid(pt_valid), .pt_ready(pt_ready), .pt_data(pt_data), .ct_valid(ct_valid), .ct_ready(ct_ready),
    .ct_data(ct_data), .core_K(core_K), .core_M(core_M), .core_C(core_C), .busy(busy));
  present_ctr_ctrl #(.CORE_LAT(5)) dut5 (
    .clk(clk), .rst(rst), .key_load(key_load), .key_in(key_in), .iv_load(iv_load), .iv_in(iv_in),
    .pt_valid(pv5), .pt_ready(pr5), .pt_data(pt_data), .ct_valid(cv5), .ct_ready(1'b1),
    .ct_data(ct5), .core_K(ck5), .core_M(cm5), .core_C(cc5), .busy(busy5));
  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [63:0] t;
    t = 64'h2174_8FE3_DA09_B65C;
    return t[{x, 2'b00} +: 4];
  endfunction
  function automatic logic [63:0] present80(input logic [63:0] m, input logic [79:0] key);
    logic [63:0] s, p;
    logic [79:0] k;
    s = m;
    k = key;
    for (int r = 1; r <= 31; r++) begin
      s = s ^ k[79:16];
      for (int i = 0; i < 16; i++) s[4*i +: 4] = sbox(s[4*i +: 4]);
      p = '0;
      for (int i = 0; i < 64; i++) p[(i == 63) ? 63 : (i * 16) % 63] = s[i];
      s = p;
      k = {k[18:0], k[79:19]};
      k[79:76] = sbox(k[79:76]);
      k[19:15] = k[19:15] ^ 5'(r);
    end
    return s ^ k[79:16];
  endfunction
  function automatic logic [63:0] nxt(input logic [63:0] c);
`ifdef PRESENT_CTR_NONCE_EN
    return {c[63:32], c[31:0] + 32'd1};
`else
    return c + 64'd1;
`endif
  endfunction
  always @(posedge clk) begin
    cp[0] <= present80(core_M, core_K);
    for (int i = 1; i < LAT; i++) cp[i] <= cp[i-1];
    cp5[0] <= cm5 ^ ck5[79:16];
    for (int i = 1; i < 5; i++) cp5[i] <= cp5[i-1];
  end
  assign core_C = cp[LAT-1];
  assign cc5 = cp5[4];
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic cfg(input logic kl, input logic [79:0] k, input logic il, input logic [63:0] iv);
    key_load = kl; key_in = k; iv_load = il; iv_in = iv;
    tick;
    key_load = 0; iv_load = 0;
    if (kl) key_m = k;
    if (il) ctr_m = iv;
  endtask
  task automatic send(input logic [63:0] pt, input logic [63:0] lit, input logic use_lit);
    int n = 0;
    while (!pt_ready && n < 50) begin tick; n++; end
    chk("pt_ready_before_send", 80'(pt_ready), 80'(1));
    sb.push_back(use_lit ? lit : present80(ctr_m, key_m) ^ pt);
    pt_valid = 1; pt_data = pt;
    tick;
    pt_valid = 0;
    chk("core_M_at_accept", 80'(core_M), 80'(ctr_m));
    chk("core_K_at_accept", core_K, key_m);
    chk("busy_in_wait", 80'(busy), 80'(1));
    ctr_m = nxt(ctr_m);
  endtask
  task automatic wait_ct(input int lat);
    int n = 0;
    while (!ct_valid && n < 30) begin tick; n++; end
    chk("ct_latency", 80'(n), 80'(lat));
  endtask
  task automatic take;
    logic [63:0] e;
    e = sb.size() > 0 ? sb.pop_front() : 64'hx;
    ct_ready = 1;
    chk("ct_data", 80'(ct_data), 80'(e));
    tick;
    ct_ready = 0;
    chk("ct_valid_drop", 80'(ct_valid), 80'(0));
    chk("pt_ready_after_out", 80'(pt_ready), 80'(1));
  endtask
  initial begin
    int n;
    ctr_m = '0; key_m = '0;
    repeat (3) tick;
    chk("rst_pt_ready", 80'(pt_ready), 80'(0));
    chk("rst_ct_valid", 80'(ct_valid), 80'(0));
    chk("rst_ct_data", 80'(ct_data), 80'(0));
    chk("rst_core_K", core_K, 80'(0));
    chk("rst_core_M", 80'(core_M), 80'(0));
    chk("rst_busy", 80'(busy), 80'(0));
    rst = 0;
    tick;
    chk("nokey_pt_ready", 80'(pt_ready), 80'(0));
    cfg(1, '0, 1, '0);
    chk("ready_after_key", 80'(pt_ready), 80'(1));
    // CORE_LAT=5 instance: valid six edges after accept
    pv5 = 1; pt_data = 64'hA5A5_5A5A_0F0F_F0F0;
    tick;
    pv5 = 0;
    n = 0;
    while (!cv5 && n < 30) begin tick; n++; end
    chk("lat5_edges", 80'(n), 80'(6));
    chk("lat5_ct", 80'(ct5), 80'(64'hA5A5_5A5A_0F0F_F0F0));
    tick;
    // zero key / zero iv
    send(64'h0, 64'h5579_C138_7B22_8445, 1);
    wait_ct(LAT + 1);
    take;
    send(64'h0, 64'h0, 0);
    wait_ct(LAT + 1);
    take;
    // counter wrap with all-ones key
    cfg(1, '1, 1, '1);
    send(64'h0, 64'h3333_DCD3_2132_10D2, 1);
    wait_ct(LAT + 1);
    take;
    send(64'h0, 64'hE72C_46C0_F594_5049, FULL);
    wait_ct(LAT + 1);
    take;
    // plaintext XOR
    cfg(1, '0, 1, '1);
    send('1, 64'h5EED_0038_D097_BE84, 1);
    wait_ct(LAT + 1);
    take;
    // backpressure: output held, config pulses ignored
    send(64'h0123_4567_89AB_CDEF, 64'h0, 0);
    wait_ct(LAT + 1);
    for (int i = 0; i < 10; i++) begin
      key_load = (i == 3); iv_load = (i == 3);
      key_in = 80'hDEAD_BEEF_0000_1111_2222; iv_in = 64'h5555_AAAA_5555_AAAA;
      tick;
      key_load = 0; iv_load = 0;
      chk("bp_ct_data", 80'(ct_data), 80'(sb[0]));
      chk("bp_ct_valid", 80'(ct_valid), 80'(1));
      chk("bp_pt_ready", 80'(pt_ready), 80'(0));
      chk("bp_core_K", core_K, key_m);
    end
    take;
    send(64'hFFFF_0000_FFFF_0000, 64'h0, 0);
    wait_ct(LAT + 1);
    take;
    // low-word wrap (nonce build keeps upper word)
    cfg(0, '0, 1, 64'h1234_5678_FFFF_FFFF);
    send(64'h1, 64'h0, 0);
    wait_ct(LAT + 1);
    take;
    send(64'h2, 64'h0, 0);
    wait_ct(LAT + 1);
    take;
    // reset one cycle after accept
    send(64'hCAFE_F00D_1234_5678, 64'h0, 0);
    tick;
    rst = 1;
    tick;
    rst = 0;
    void'(sb.pop_back());
    ctr_m = '0; key_m = '0;
    for (int i = 0; i < 6; i++) begin
      chk("rst_mid_ct_valid", 80'(ct_valid), 80'(0));
      chk("rst_mid_pt_ready", 80'(pt_ready), 80'(0));
      tick;
    end
    chk("rst_mid_core_K", core_K, 80'(0));
    cfg(1, 80'h0F0F_0F0F_0F0F_0F0F_0F0F, 0, '0);
    send(64'h7777_8888_9999_AAAA, 64'h0, 0);
    wait_ct(LAT + 1);
    take;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
